// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cnn_pkg
//  Description : Shared defaults for the CNN front-end line/window blocks:
//                pixel width, line geometry and the convolution window size.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

   // Default pixel width in bits (pixels are signed)
   localparam int c_WIDTH        = 8;
   // Default pixels per line and matching column address width
   localparam int c_LINEWIDTH    = 32;
   localparam int c_LNLINEWIDTH  = 5;
   // Default lines per frame
   localparam int c_FRAME_HEIGHT = 32;
   // Window is c_K x c_K
   localparam int c_K            = 3;

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/line_mem.sv
`default_nettype none
// ============================================================================
//  Module      : line_mem
//  Description : One-line buffer, 1 read port / 1 write port. The read data
//                is registered and holds its value while ren is low. A read
//                and write to the same address in one cycle return the data
//                stored before the write. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_mem
   import cnn_pkg::*;
#(
   parameter int WIDTH = c_WIDTH,
   parameter int DEPTH = c_LINEWIDTH,
   parameter int AW    = c_LNLINEWIDTH
) (
   input  logic             clk,
   input  logic             ren,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata,
   input  logic             wen,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Write port: storage array, deliberately without reset
   always_ff @(posedge clk) begin
      if (wen) begin
         r_mem[waddr] <= wdata;
      end
   end

   // Read port: registered output; non-blocking update gives read-old on collision
   always_ff @(posedge clk) begin
      if (ren) begin
         r_rdata <= r_mem[raddr];
      end
   end

   assign rdata = r_rdata;

endmodule : line_mem
`default_nettype wire

// File: rtl/line_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : line_window_ctrl
//  Description : Converts a raster-order pixel stream into a stream of 3x3
//                windows using two line memories. Valid/ready on both sides;
//                a single pipeline enable stalls every stage together, so no
//                pixel is lost or duplicated under backpressure. Windows that
//                would span the previous line's tail or the previous frame
//                (first two columns / first two rows) are never flagged valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_window_ctrl
   import cnn_pkg::*;
#(
   parameter int WIDTH        = c_WIDTH,
   parameter int LINEWIDTH    = c_LINEWIDTH,
   parameter int LNLINEWIDTH  = c_LNLINEWIDTH,
   parameter int FRAME_HEIGHT = c_FRAME_HEIGHT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [WIDTH-1:0]       in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [c_K*c_K*WIDTH-1:0]      out_win,
   output logic                          out_last
);

   localparam int c_ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

   localparam logic [LNLINEWIDTH-1:0] c_COL_LAST = LNLINEWIDTH'(LINEWIDTH - 1);
   localparam logic [c_ROW_W-1:0]     c_ROW_LAST = c_ROW_W'(FRAME_HEIGHT - 1);
   // A window is complete once its right column / bottom row index reaches K-1
   localparam logic [LNLINEWIDTH-1:0] c_COL_MIN  = LNLINEWIDTH'(c_K - 1);
   localparam logic [c_ROW_W-1:0]     c_ROW_MIN  = c_ROW_W'(c_K - 1);

   // ---------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------
   logic w_en;
   logic w_accept;

   logic                   r_out_valid;
   logic                   r_out_last;

   assign w_en     = !r_out_valid || out_ready;
   assign w_accept = in_valid && w_en;
   assign in_ready = w_en;

   // ---------------------------------------------------------------------
   // Raster position of the next incoming pixel
   // ---------------------------------------------------------------------
   logic [LNLINEWIDTH-1:0] r_col;
   logic [c_ROW_W-1:0]     r_row;

   // Column/row counters advance only on an accepted pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (r_col == c_COL_LAST) begin
            r_col <= '0;
            if (r_row == c_ROW_LAST) begin
               r_row <= '0;
            end else begin
               r_row <= r_row + 1'b1;
            end
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 1: pixel and its position, aligned with the memory read data
   // ---------------------------------------------------------------------
   logic                   r_s1_valid;
   logic [WIDTH-1:0]       r_s1_pix;
   logic [LNLINEWIDTH-1:0] r_s1_col;
   logic [c_ROW_W-1:0]     r_s1_row;

   // Stage-1 register loads whenever the pipeline moves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_pix   <= '0;
         r_s1_col   <= '0;
         r_s1_row   <= '0;
      end else if (w_en) begin
         r_s1_valid <= in_valid;
         r_s1_pix   <= in_data;
         r_s1_col   <= r_col;
         r_s1_row   <= r_row;
      end
   end

   // ---------------------------------------------------------------------
   // Line memories: L0 holds line row-1, L1 holds line row-2. L1 is fed
   // from L0's read data one cycle later, so each line cascades down.
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] w_l0_rdata;
   logic [WIDTH-1:0] w_l1_rdata;
   logic             w_l1_wen;

   assign w_l1_wen = w_en && r_s1_valid;

   line_mem #(
      .WIDTH (WIDTH),
      .DEPTH (LINEWIDTH),
      .AW    (LNLINEWIDTH)
   ) u_l0 (
      .clk   (clk),
      .ren   (w_accept),
      .raddr (r_col),
      .rdata (w_l0_rdata),
      .wen   (w_accept),
      .waddr (r_col),
      .wdata (in_data)
   );

   line_mem #(
      .WIDTH (WIDTH),
      .DEPTH (LINEWIDTH),
      .AW    (LNLINEWIDTH)
   ) u_l1 (
      .clk   (clk),
      .ren   (w_accept),
      .raddr (r_col),
      .rdata (w_l1_rdata),
      .wen   (w_l1_wen),
      .waddr (r_s1_col),
      .wdata (w_l0_rdata)
   );

   // ---------------------------------------------------------------------
   // Window shift register: column K-1 is the newest column
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] r_win [c_K][c_K];

   // Shift the window left by one column per stage-1 pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < c_K; r++) begin
            for (int c = 0; c < c_K; c++) begin
               r_win[r][c] <= '0;
            end
         end
      end else if (w_en && r_s1_valid) begin
         for (int r = 0; r < c_K; r++) begin
            for (int c = 0; c < c_K - 1; c++) begin
               r_win[r][c] <= r_win[r][c+1];
            end
         end
         r_win[0][c_K-1] <= w_l1_rdata;
         r_win[1][c_K-1] <= w_l0_rdata;
         r_win[2][c_K-1] <= r_s1_pix;
      end
   end

   // Output flags: valid only once the window lies wholly inside this frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (w_en) begin
         r_out_valid <= r_s1_valid && (r_s1_row >= c_ROW_MIN) && (r_s1_col >= c_COL_MIN);
         r_out_last  <= r_s1_valid && (r_s1_col == c_COL_LAST) && (r_s1_row == c_ROW_LAST);
      end
   end

   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;

   // Flatten the window: element (r,c) at bits [(K*r+c)*WIDTH +: WIDTH]
   for (genvar gr = 0; gr < c_K; gr++) begin : g_row
      for (genvar gc = 0; gc < c_K; gc++) begin : g_col
         assign out_win[(gr*c_K+gc)*WIDTH +: WIDTH] = r_win[gr][gc];
      end
   end

endmodule : line_window_ctrl
`default_nettype wire

// File: tb/tb_line_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_window_ctrl
//  Description : Self-checking bench for line_window_ctrl (8x6 frames,
//                pixel = row*16+col). Expected windows are computed directly
//                from frame geometry and compared in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_window_ctrl;

   localparam int W    = 8;
   localparam int LW   = 8;
   localparam int LNLW = 3;
   localparam int FH   = 6;
   localparam int NPIX = LW * FH;
   localparam int NWIN = (LW - 2) * (FH - 2);

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [W-1:0]  in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [9*W-1:0]       out_win;
   logic                 out_last;

   always #5 clk = ~clk;

   line_window_ctrl #(
      .WIDTH        (W),
      .LINEWIDTH    (LW),
      .LNLINEWIDTH  (LNLW),
      .FRAME_HEIGHT (FH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_win   (out_win),
      .out_last  (out_last)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [9*W:0] exp_q [$];    // {last, window}
   int           feed_left;
   int           pix_idx;
   int           accepts;
   int           win_cnt;
   int           last_cnt;
   int           edge_cnt = 0;
   int           acc_edge22;
   int           first_edge;
   bit           seen_first;
   bit           stall_prev;
   logic [9*W-1:0] prev_win;
   int           stall_req = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] pix_of(input int idx);
      int p;
      p = idx % NPIX;
      return W'((p / LW) * 16 + (p % LW));
   endfunction

   // Every 3x3 neighbourhood fully inside the frame, in raster order of its
   // bottom-right pixel
   task automatic build_expected(input int nframes);
      logic [9*W-1:0] win;
      for (int f = 0; f < nframes; f++) begin
         for (int r = 2; r < FH; r++) begin
            for (int c = 2; c < LW; c++) begin
               win = '0;
               for (int i = 0; i < 3; i++) begin
                  for (int j = 0; j < 3; j++) begin
                     win[(3*i+j)*W +: W] = W'((r - 2 + i) * 16 + (c - 2 + j));
                  end
               end
               exp_q.push_back({(r == FH-1) && (c == LW-1), win});
            end
         end
      end
   endtask

   // One clock cycle: drive at the falling edge, observe, then pass the rising edge
   task automatic step(input int iv_pct, input int or_pct);
      logic [9*W:0] e;
      bit           acc;
      @(negedge clk);
      if (stall_prev) begin
         chk("stall_win_stable", 128'(out_win), 128'(prev_win));
         chk("stall_valid_held", 128'(out_valid), 128'(1));
      end
      in_valid  = (feed_left > 0) && (int'($urandom_range(99)) < iv_pct);
      in_data   = in_valid ? pix_of(pix_idx) : W'($urandom);
      out_ready = (int'($urandom_range(99)) < or_pct);
      if (stall_req > 0 && out_valid) begin
         out_ready = 1'b0;
         stall_req--;
      end
      #1;
      if (out_valid && !seen_first) begin
         seen_first = 1'b1;
         first_edge = edge_cnt;
      end
      if (out_valid && out_ready) begin
         chk("window_expected", 128'(exp_q.size() > 0), 128'(1));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("window_data", 128'(out_win), 128'(e[9*W-1:0]));
            chk("window_last", 128'(out_last), 128'(e[9*W]));
            if (win_cnt % NWIN == 0) begin
               chk("first_win_00", 128'(out_win[0 +: W]), 128'(8'h00));
               chk("first_win_22", 128'(out_win[8*W +: W]), 128'(8'h22));
            end
            if (win_cnt % NWIN == 6) begin
               chk("wrap_win_00", 128'(out_win[0 +: W]), 128'(8'h10));
               chk("wrap_win_22", 128'(out_win[8*W +: W]), 128'(8'h32));
            end
            if (win_cnt % NWIN == NWIN - 1) begin
               chk("last_win_22", 128'(out_win[8*W +: W]), 128'(8'h57));
            end
         end
         win_cnt++;
         if (out_last) last_cnt++;
      end
      if (out_valid && !out_ready) begin
         chk("stall_in_ready", 128'(in_ready), 128'(0));
         stall_prev = 1'b1;
         prev_win   = out_win;
      end else begin
         stall_prev = 1'b0;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      edge_cnt++;
      if (acc) begin
         if (pix_idx == 18) acc_edge22 = edge_cnt;
         pix_idx++;
         feed_left--;
         accepts++;
      end
   endtask

   task automatic run(input int nframes, input int iv_pct, input int or_pct);
      int budget;
      build_expected(nframes);
      feed_left  = nframes * NPIX;
      pix_idx    = 0;
      accepts    = 0;
      win_cnt    = 0;
      last_cnt   = 0;
      seen_first = 1'b0;
      stall_prev = 1'b0;
      acc_edge22 = -100;
      first_edge = -1;
      budget     = 0;
      while ((feed_left > 0 || exp_q.size() > 0) && budget < 4000) begin
         step(iv_pct, or_pct);
         budget++;
      end
      chk("run_within_budget", 128'(budget < 4000), 128'(1));
      chk("window_count", 128'(win_cnt), 128'(nframes * NWIN));
      chk("last_count", 128'(last_cnt), 128'(nframes));
      chk("first_latency", 128'(first_edge), 128'(acc_edge22 + 1));
      exp_q.delete();
      in_valid = 1'b0;
   endtask

   initial begin
      int guard;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_last", 128'(out_last), 128'(0));
      chk("rst_out_win", 128'(out_win), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      rst_n = 1'b1;

      // Single frame, no stall
      run(1, 100, 100);

      // Five-cycle backpressure while a window is pending
      stall_req = 5;
      run(1, 100, 100);
      chk("stall_cycles_used", 128'(stall_req), 128'(0));

      // Two back-to-back frames
      run(2, 100, 100);

      // Reset in the middle of a frame after 20 accepted pixels
      build_expected(1);
      feed_left  = NPIX;
      pix_idx    = 0;
      accepts    = 0;
      win_cnt    = 0;
      last_cnt   = 0;
      stall_prev = 1'b0;
      seen_first = 1'b1;
      guard      = 0;
      while (accepts < 20 && guard < 200) begin
         step(100, 100);
         guard++;
      end
      chk("pre_reset_accepts", 128'(accepts), 128'(20));
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 128'(out_valid), 128'(0));
      chk("async_rst_out_last", 128'(out_last), 128'(0));
      chk("async_rst_out_win", 128'(out_win), 128'(0));
      chk("async_rst_in_ready", 128'(in_ready), 128'(1));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      run(1, 100, 100);

      // Random input gaps and random backpressure
      run(1, 50, 50);
      run(2, 70, 60);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_line_window_ctrl
`default_nettype wire

// File: doc/line_window_ctrl.md
LINE_WINDOW_CTRL -- requirements
Module: line_window_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: pixel width in bits, signed.
REQ-002 Parameter LINEWIDTH, default 32: pixels per line.
REQ-003 Parameter LNLINEWIDTH, default 5: column address width, ceil(log2(LINEWIDTH)).
REQ-004 Parameter FRAME_HEIGHT, default 32: lines per frame.
REQ-005 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port in_valid, input, 1: in_data is valid.
REQ-008 Port in_ready, output, 1: block accepts a pixel this cycle.
REQ-009 Port in_data, input, WIDTH (signed): raster-order pixel stream.
REQ-010 Port out_valid, output, 1: out_win holds a complete 3x3 window.
REQ-011 Port out_ready, input, 1: downstream consumes the window.
REQ-012 Port out_win, output, 9*WIDTH: window; element (r,c) at bits [(3r+c)*WIDTH +: WIDTH]; r=0 is the oldest line, c=0 the oldest column.
REQ-013 Port out_last, output, 1: qualifies out_valid; window ends at the last pixel of the frame.

Function
REQ-014 Pipeline enable en = !out_valid || out_ready; in_ready shall equal en; accept = in_valid && en.
REQ-015 Column counter col (0..LINEWIDTH-1) and row counter row (0..FRAME_HEIGHT-1) shall advance on each accept only.
REQ-016 On accept at the last column, col shall wrap to 0 and row shall increment; at the last column of the last row, both shall wrap to 0.
REQ-017 Two line memories are used: L0 holds line row-1, L1 holds line row-2.
REQ-018 On accept, both memories shall be read at address col, and in_data shall be written to L0 at col in the same cycle.
REQ-019 A same-address read/write collision shall return the old data.
REQ-020 Stage-1 registers (pixel, col, row, valid) shall load on en.
REQ-021 When en && s1_valid, the old L0 read data shall be written to L1 at s1_col.
REQ-022 When en && s1_valid, the window shall shift one column: column 2 receives {L1 data, L0 data, s1 pixel} into rows 0..2.
REQ-023 When en, out_valid shall load s1_valid && s1_row>=2 && s1_col>=2; otherwise it holds.
REQ-024 Latency: a pixel accepted at edge t produces its window at edge t+1 when there is no stall.
REQ-025 When out_valid && !out_ready, in_ready, stage 1, the window, the memory read data and the counters shall all hold; no pixel is lost or duplicated.
REQ-026 Windows whose right column is col 0 or col 1 shall never be flagged valid.
REQ-027 Rows 0 and 1 of every frame shall never produce valid windows, whatever the memories contain from the prior frame.
REQ-028 out_last shall load on en as s1_valid && s1_col==LINEWIDTH-1 && s1_row==FRAME_HEIGHT-1.
REQ-029 Each frame shall emit exactly (LINEWIDTH-2)*(FRAME_HEIGHT-2) valid windows.

Reset
REQ-030 While rst_n is low: col=0, row=0, s1_valid=0, out_valid=0, out_last=0, out_win=0; in_ready follows REQ-014 and reads 1.
REQ-031 Line memory contents shall not be reset.
REQ-032 After a mid-frame reset, the next accepted pixel shall be treated as (row 0, col 0).

Structure
REQ-033 Shared package cnn_pkg shall hold default WIDTH, LINEWIDTH, LNLINEWIDTH, FRAME_HEIGHT and the window size constant K=3.
REQ-034 Sub-module line_mem (1R1W, registered read output held when ren=0, read-old on collision) shall be instantiated twice, for L0 and L1.

Verification (LINEWIDTH=8, FRAME_HEIGHT=6, pixel = row*16+col)
REQ-035 One frame with no stall -> exactly 24 windows; the first window appears 1 cycle after pixel 0x22 with (0,0)=0x00 and (2,2)=0x22; the last window has out_last=1 with (2,2)=0x57.
REQ-036 out_ready low for 5 cycles while out_valid=1 -> in_ready=0; out_win stable; all 24 windows are delivered in order.
REQ-037 Line wrap: pixels (3,0) and (3,1) produce no window; the window after (3,2) has (0,0)=0x10 and (2,2)=0x32.
REQ-038 Two back-to-back frames -> the second frame emits its first window only after pixel (2,2); a total of 48 windows and 2 out_last pulses.
REQ-039 rst_n pulsed low after 20 accepts -> out_valid=0 asynchronously; a restarted frame yields 24 correct windows.
REQ-040 Random in_valid gaps (50%) combined with random out_ready -> output sequence identical to REQ-035.
